preq_pgnt_responder: RTL



---
 rtl/preq_pgnt_responder_pkg.sv | 16 +
 rtl/preq_pgnt_responder_if.sv | 14 +
 rtl/preq_pgnt_responder_rr_arbiter.sv | 42 ++++
 rtl/preq_pgnt_responder.sv | 116 +++++++++++
 4 files changed

// File: rtl/preq_pgnt_responder_pkg.sv
// Shared types and limits for the preq/pgnt grant responder.
package preq_pgnt_pkg;

    localparam int MAX_NREQ = 16;
    localparam int MAX_LAT  = 8;

    // Requester index, wide enough for MAX_NREQ requesters
    typedef logic [3:0] idx_t;

    // One slot of the accept-to-grant delay line
    typedef struct packed {
        logic valid;
        idx_t idx;
    } dly_ent_t;

endpackage

// File: rtl/preq_pgnt_responder_if.sv
// Request/grant bundle between requesters (master) and the responder (slave).
interface preq_pgnt_responder_if #(
    parameter int NREQ = 4,
    parameter int CNTW = 8
);
    logic [NREQ-1:0] preq;
    logic [NREQ-1:0] pacc;
    logic [NREQ-1:0] pgnt;
    logic            busy;
    logic [CNTW-1:0] gnt_cnt;

    modport master (output preq, input pacc, input pgnt, input busy, input gnt_cnt);
    modport slave  (input preq, output pacc, output pgnt, output busy, output gnt_cnt);
endinterface

// File: rtl/preq_pgnt_responder_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after ptr_i,
// wrapping from NREQ-1 back to 0.
module rr_arbiter
    import preq_pgnt_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] elig_i,
    input  idx_t            ptr_i,
    output logic [NREQ-1:0] win_oh_o,
    output idx_t            win_idx_o,
    output logic            win_vld_o
);

    logic [MAX_NREQ-1:0] elig_x;
    logic [4:0]          pos;

    // Scan from farthest to nearest offset so the nearest eligible requester wins
    always_comb begin
        elig_x            = '0;
        elig_x[NREQ-1:0]  = elig_i;
        pos               = '0;
        win_idx_o         = '0;
        win_vld_o         = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_i} + 5'(k);
            if (pos >= 5'(NREQ)) pos = pos - 5'(NREQ);
            if (elig_x[pos[3:0]]) begin
                win_idx_o = pos[3:0];
                win_vld_o = 1'b1;
            end
        end
    end

    // One-hot form of the chosen index
    always_comb begin
        win_oh_o = '0;
        for (int i = 0; i < NREQ; i++)
            win_oh_o[i] = win_vld_o && (win_idx_o == idx_t'(i));
    end

endmodule

// File: rtl/preq_pgnt_responder.sv
// Grant-side responder: round-robin accepts one request per cycle and returns
// a one-cycle pgnt pulse exactly LAT cycles later. A requester stays masked
// from its accept edge through its grant cycle.
// Optional macro REQ_GNT_SVA_EN compiles embedded protocol assertions/covers.
module preq_pgnt_responder
    import preq_pgnt_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int CNTW = 8
) (
    input  logic                  pclk,
    input  logic                  presetn,
    preq_pgnt_responder_if.slave  bus
);

    logic [NREQ-1:0] req_ok, elig, acc_oh;
    logic [NREQ-1:0] inflight_q, inflight_d;
    logic [NREQ-1:0] pgnt_q, pgnt_d;
    idx_t            rr_ptr_q, rr_ptr_d, acc_idx;
    logic            acc_vld;
    logic [CNTW-1:0] cnt_q, cnt_d;
    dly_ent_t        acc_ent;

    function automatic logic [NREQ-1:0] ent_oh(input dly_ent_t e);
        logic [NREQ-1:0] oh;
        for (int i = 0; i < NREQ; i++)
            oh[i] = e.valid && (e.idx == idx_t'(i));
        return oh;
    endfunction

    // X or Z on a request line counts as "not requesting"
    always_comb begin
        req_ok = '0;
        for (int i = 0; i < NREQ; i++)
            req_ok[i] = (bus.preq[i] === 1'b1);
    end

    assign elig = req_ok & ~inflight_q;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .elig_i    (elig),
        .ptr_i     (rr_ptr_q),
        .win_oh_o  (acc_oh),
        .win_idx_o (acc_idx),
        .win_vld_o (acc_vld)
    );

    assign acc_ent = '{valid: acc_vld, idx: acc_idx};

    // Delay line: LAT-1 index stages feeding the registered pgnt stage
    if (LAT == 1) begin : g_lat1
        always_comb pgnt_d = acc_oh;
    end else begin : g_dly
        dly_ent_t dly_q [LAT-1];

        // Shift accepted indices toward the grant stage
        always_ff @(posedge pclk or negedge presetn) begin
            if (!presetn) begin
                for (int k = 0; k < LAT - 1; k++) dly_q[k] <= '0;
            end else begin
                dly_q[0] <= acc_ent;
                for (int k = 1; k < LAT - 1; k++) dly_q[k] <= dly_q[k-1];
            end
        end

        always_comb pgnt_d = ent_oh(dly_q[LAT-2]);
    end

    // Next state: grant clears its in-flight bit in the same edge an accept sets one
    always_comb begin
        inflight_d = (inflight_q & ~pgnt_q) | acc_oh;
        rr_ptr_d   = rr_ptr_q;
        if (acc_vld)
            rr_ptr_d = (acc_idx == idx_t'(NREQ - 1)) ? idx_t'(0) : acc_idx + idx_t'(1);
        cnt_d      = cnt_q + CNTW'(|pgnt_q);
    end

    // State registers; reset discards anything in flight
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            inflight_q <= '0;
            rr_ptr_q   <= '0;
            pgnt_q     <= '0;
            cnt_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            rr_ptr_q   <= rr_ptr_d;
            pgnt_q     <= pgnt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.pacc    = acc_oh;
    assign bus.pgnt    = pgnt_q;
    assign bus.busy    = |inflight_q;
    assign bus.gnt_cnt = cnt_q;

`ifdef REQ_GNT_SVA_EN
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sva
        a_lat: assert property (@(posedge pclk) disable iff (!presetn)
                                bus.pacc[gi] |-> ##LAT bus.pgnt[gi])
            else $error("%m: accept without grant LAT cycles later at %0t", $stime);
        c_lat: cover property (@(posedge pclk) disable iff (!presetn)
                               bus.pacc[gi] ##LAT bus.pgnt[gi]);
    end

    a_acc_1h: assert property (@(posedge pclk) disable iff (!presetn) $onehot0(bus.pacc))
        else $error("%m: pacc not one-hot at %0t", $stime);
    a_gnt_1h: assert property (@(posedge pclk) disable iff (!presetn) $onehot0(bus.pgnt))
        else $error("%m: pgnt not one-hot at %0t", $stime);
    a_req_known: assert property (@(posedge pclk) disable iff (!presetn) !$isunknown(bus.preq))
        else $error("%m: preq unknown at %0t", $stime);
`endif

endmodule
